gsim_ctrl: RTL and testbench

GSIM_CTRL -- requirements
Module: gsim_ctrl

---
 rtl/gsim_ctrl.sv | 126 ++++++++++++
 tb/tb_gsim_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_ctrl.sv
// Sequencer for a 16-row Gauss-Seidel solver: loads the b-vector, issues row
// updates for N_ITER sweeps, then streams the 16-entry x-vector result.
module gsim_ctrl #(
  parameter int N_ITER = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en,
  input  logic       calc_done,
  output logic       b_wr_en,
  output logic [3:0] b_wr_addr,
  output logic       calc_start,
  output logic [3:0] row_idx,
  output logic [5:0] nb_mask,
  output logic [3:0] x_rd_addr,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT,
    DONE
  } state_t;

  localparam logic [7:0] ITER_LAST = 8'(N_ITER);

  state_t     state_reg, state_next;
  logic [3:0] load_reg, load_next;
  logic [3:0] row_reg, row_next;
  logic [3:0] x_reg, x_next;
  logic [7:0] iter_reg, iter_next;
  logic       start_reg;
  logic       valid_reg;
  logic       busy_reg;

  // Strobe-type outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      load_reg  <= 4'd0;
      row_reg   <= 4'd0;
      x_reg     <= 4'd0;
      iter_reg  <= 8'd0;
      start_reg <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      load_reg  <= load_next;
      row_reg   <= row_next;
      x_reg     <= x_next;
      iter_reg  <= iter_next;
      start_reg <= (state_next == ISSUE);
      valid_reg <= (state_next == OUT);
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    load_next  = load_reg;
    row_next   = row_reg;
    iter_next  = iter_reg;
    x_next     = 4'd0;
    case (state_reg)
      IDLE: begin
        if (in_en) begin
          load_next = load_reg + 4'd1;
          if (load_reg == 4'd15) begin
            state_next = ISSUE;
            load_next  = 4'd0;
            row_next   = 4'd0;
            iter_next  = 8'd0;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (calc_done) begin
          if (row_reg != 4'd15) begin
            row_next   = row_reg + 4'd1;
            state_next = ISSUE;
          end else begin
            row_next   = 4'd0;
            iter_next  = iter_reg + 8'd1;
            state_next = (iter_reg + 8'd1 == ITER_LAST) ? OUT : ISSUE;
          end
        end
      end
      OUT: begin
        if (x_reg == 4'd15) begin
          state_next = DONE;
        end else begin
          x_next = x_reg + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign b_wr_en    = (state_reg == IDLE) && in_en;
  assign b_wr_addr  = load_reg;
  assign calc_start = start_reg;
  assign row_idx    = row_reg;
  assign x_rd_addr  = x_reg;
  assign out_valid  = valid_reg;
  assign busy       = busy_reg;
  assign iter_cnt   = iter_reg;

  // Neighbour i+k exists only while it stays inside rows 0..15.
  assign nb_mask = {row_reg <= 4'd12, row_reg <= 4'd13, row_reg <= 4'd14,
                    row_reg >= 4'd1,  row_reg >= 4'd2,  row_reg >= 4'd3};

endmodule

// File: tb/tb_gsim_ctrl.sv
// Scoreboard bench for gsim_ctrl with N_ITER=2: expected write addresses,
// row issues and output addresses are queued at stimulus time.
module tb_gsim_ctrl;

  localparam int NIT = 2;
  localparam int M_OFF = 0, M_HOLD = 1, M_DELAY = 2, M_ISSUE = 3;

  typedef struct packed {
    logic [3:0] row;
    logic [7:0] iter;
  } issue_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_en;
  logic       calc_done;
  logic       b_wr_en;
  logic [3:0] b_wr_addr;
  logic       calc_start;
  logic [3:0] row_idx;
  logic [5:0] nb_mask;
  logic [3:0] x_rd_addr;
  logic       out_valid;
  logic       busy;
  logic [7:0] iter_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_mode = M_OFF;
  int done_delay = 1;
  int cd_cnt = 0;
  int epoch = 0;
  int exp_gap = 0;
  int issue_seen = 0;
  int out_seen = 0;
  int last_cyc = 0;
  int last_epoch = -1;
  logic prev_ov = 1'b0;
  logic busy_pend = 1'b0;

  logic [3:0] exp_wr[$];
  issue_t     exp_issue[$];
  logic [3:0] exp_out[$];

  gsim_ctrl #(.N_ITER(NIT)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .calc_done(calc_done),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .calc_start(calc_start),
    .row_idx(row_idx), .nb_mask(nb_mask), .x_rd_addr(x_rd_addr),
    .out_valid(out_valid), .busy(busy), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [5:0] mask_of(input logic [3:0] r);
    int offs[6] = '{-3, -2, -1, 1, 2, 3};
    logic [5:0] m;
    for (int i = 0; i < 6; i++) begin
      int t;
      t = int'(r) + offs[i];
      m[i] = (t >= 0) && (t <= 15);
    end
    return m;
  endfunction

  // calc_done responder, the only driver of calc_done.
  always @(posedge clk) begin
    #1;
    case (done_mode)
      M_HOLD:  calc_done = 1'b1;
      M_ISSUE: calc_done = calc_start;
      M_DELAY: begin
        calc_done = 1'b0;
        if (cd_cnt != 0) begin
          cd_cnt--;
          if (cd_cnt == 0) calc_done = 1'b1;
        end
        if (calc_start) cd_cnt = done_delay;
      end
      default: begin
        calc_done = 1'b0;
        cd_cnt = 0;
      end
    endcase
  end

  // Monitor: pops the scoreboard whenever the DUT produces an output event.
  always @(negedge clk) begin
    if (!reset) begin
      if (b_wr_en) begin
        if (exp_wr.size() == 0) check("wr_extra", 1, 0);
        else check("wr_addr", b_wr_addr, exp_wr.pop_front());
      end
      check("mask_decode", nb_mask, mask_of(row_idx));
      if (calc_start) begin
        issue_t e;
        issue_seen++;
        if (exp_issue.size() == 0) check("issue_extra", 1, 0);
        else begin
          e = exp_issue.pop_front();
          check("issue_row", row_idx, e.row);
          check("issue_mask", nb_mask, mask_of(e.row));
          check("issue_iter", iter_cnt, e.iter);
        end
        if (exp_gap != 0 && last_epoch == epoch) check("issue_gap", cyc - last_cyc, exp_gap);
        last_cyc = cyc;
        last_epoch = epoch;
      end
      if (out_valid) begin
        out_seen++;
        check("out_busy", busy, 1);
        if (exp_out.size() == 0) check("out_extra", 1, 0);
        else check("out_addr", x_rd_addr, exp_out.pop_front());
      end else begin
        check("x_idle", x_rd_addr, 0);
      end
      if (prev_ov && !out_valid) begin
        check("busy_done", busy, 1);
        busy_pend = 1'b1;
      end else if (busy_pend) begin
        check("busy_after", busy, 0);
        busy_pend = 1'b0;
      end
      prev_ov = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int gap);
    for (int k = 0; k < 16; k++) begin
      in_en = 1'b1;
      exp_wr.push_back(4'(k));
      if (k == 15) begin
        for (int s = 0; s < NIT; s++)
          for (int r = 0; r < 16; r++) exp_issue.push_back('{row: 4'(r), iter: 8'(s)});
        for (int a = 0; a < 16; a++) exp_out.push_back(4'(a));
      end
      step();
      in_en = 1'b0;
      if (k < 15) begin
        check("busy_load", busy, 0);
        repeat (gap) step();
      end
    end
    check("start_after_load", calc_start, 1);
    check("row_after_load", row_idx, 0);
    check("iter_after_load", iter_cnt, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic finish_sweep(input int snap_i, input int snap_o);
    wait_idle(2000);
    check("final_iter", iter_cnt, NIT);
    check("issue_total", issue_seen - snap_i, 16 * NIT);
    check("out_total", out_seen - snap_o, 16);
    check("issue_q_empty", exp_issue.size(), 0);
    check("out_q_empty", exp_out.size(), 0);
    repeat (3) step();
    check("iter_hold", iter_cnt, NIT);
  endtask

  initial begin
    int si, so, n;
    reset = 1'b1;
    in_en = 1'b0;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_start", calc_start, 0);
    check("rst_valid", out_valid, 0);
    check("rst_row", row_idx, 0);
    check("rst_iter", iter_cnt, 0);
    check("rst_x", x_rd_addr, 0);
    check("rst_wr_en", b_wr_en, 0);

    // Contiguous load, calc_done held high: 2-cycle row period.
    reset = 1'b0;
    done_mode = M_HOLD;
    epoch++; exp_gap = 2; si = issue_seen; so = out_seen;
    load(0);
    check("first_mask", nb_mask, 6'b111000);
    finish_sweep(si, so);

    // Delayed completion with gapped load and in_en pulses while busy.
    done_mode = M_DELAY; done_delay = 3;
    epoch++; exp_gap = 4; si = issue_seen; so = out_seen;
    load(3);
    for (int i = 0; i < 40; i++) begin
      in_en = (i % 3 == 1);
      #1;
      if (in_en) check("wr_en_busy", b_wr_en, 0);
      step();
    end
    in_en = 1'b0;
    finish_sweep(si, so);

    // Delay 5: 6-cycle rows; reset asynchronously during WAIT of row 9, sweep 1.
    done_delay = 5;
    epoch++; exp_gap = 6;
    load(0);
    n = 0;
    while (!(calc_start && row_idx == 4'd9 && iter_cnt == 8'd1) && n < 1000) begin
      step();
      n++;
    end
    check("row9_reached", n < 1000, 1);
    step();
    reset = 1'b1;
    done_mode = M_OFF;
    #1;
    check("arst_busy", busy, 0);
    check("arst_start", calc_start, 0);
    check("arst_valid", out_valid, 0);
    check("arst_row", row_idx, 0);
    check("arst_iter", iter_cnt, 0);
    check("arst_x", x_rd_addr, 0);
    check("arst_wr_addr", b_wr_addr, 0);
    exp_issue.delete();
    exp_out.delete();
    step();
    reset = 1'b0;
    done_mode = M_HOLD;
    epoch++; exp_gap = 2; si = issue_seen; so = out_seen;
    load(0);
    finish_sweep(si, so);

    // calc_done pulsed only during ISSUE must be ignored.
    done_mode = M_ISSUE;
    epoch++; exp_gap = 0; si = issue_seen; so = out_seen;
    load(0);
    repeat (10) step();
    check("issue_pulse_row", row_idx, 0);
    check("issue_pulse_busy", busy, 1);
    check("issue_pulse_count", issue_seen - si, 1);
    done_mode = M_HOLD;
    n = 0;
    while (issue_seen - si < 2 && n < 5) begin
      step();
      n++;
    end
    check("resume_count", issue_seen - si, 2);
    finish_sweep(si, so);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
